tmds_encoder: RTL and testbench

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_encoder.sv | 108 ++++++++++
 tb/tb_tmds_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder for one colour channel.
// Stage 1 builds the transition-minimised word; stage 2 balances DC and registers the symbol.
module tmds_encoder (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       de_i,
   input  logic [7:0] data_i,
   input  logic [1:0] ctrl_i,
   output logic [9:0] tmds_o
);

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [8:0] transition_min(input logic [7:0] d);
      logic [8:0] q;
      logic       use_xnor;
      use_xnor = (popcount8(d) > 4'd4) || ((popcount8(d) == 4'd4) && !d[0]);
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   function automatic logic [9:0] ctrl_token(input logic [1:0] c);
      logic [9:0] t;
      case (c)
         2'b00:   t = 10'b1101010100;
         2'b01:   t = 10'b0010101011;
         2'b10:   t = 10'b0101010100;
         default: t = 10'b1010101011;
      endcase
      return t;
   endfunction

   logic              de_p1;
   logic [1:0]        ctrl_p1;
   logic [8:0]        q_m_p1;
   logic signed [4:0] cnt_p2;
   logic [9:0]        tmds_p2;

   // ---- stage 1: transition minimisation ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         de_p1   <= 1'b0;
         ctrl_p1 <= 2'b00;
         q_m_p1  <= '0;
      end else begin
         de_p1   <= de_i;
         ctrl_p1 <= ctrl_i;
         q_m_p1  <= transition_min(data_i);
      end
   end

   logic [3:0]        n1q;
   logic [3:0]        n0q;
   logic signed [4:0] diff_q;
   logic signed [4:0] delta_q;
   logic signed [4:0] cnt_nxt;
   logic signed [5:0] cnt_chk;
   logic [9:0]        tmds_nxt;

   always_comb begin
      n1q      = popcount8(q_m_p1[7:0]);
      n0q      = 4'd8 - n1q;
      diff_q   = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
      delta_q  = 5'sd0;
      tmds_nxt = ctrl_token(ctrl_p1);
      if (de_p1) begin
         if ((cnt_p2 == 5'sd0) || (n1q == n0q)) begin
            tmds_nxt = {~q_m_p1[8], q_m_p1[8], q_m_p1[8] ? q_m_p1[7:0] : ~q_m_p1[7:0]};
            delta_q  = q_m_p1[8] ? diff_q : -diff_q;
         end else if (((cnt_p2 > 5'sd0) && (n1q > n0q)) || ((cnt_p2 < 5'sd0) && (n0q > n1q))) begin
            tmds_nxt = {1'b1, q_m_p1[8], ~q_m_p1[7:0]};
            delta_q  = (q_m_p1[8] ? 5'sd2 : 5'sd0) - diff_q;
         end else begin
            tmds_nxt = {1'b0, q_m_p1[8], q_m_p1[7:0]};
            delta_q  = diff_q - (q_m_p1[8] ? 5'sd0 : 5'sd2);
         end
      end
      // Blanking restarts the running disparity from zero.
      cnt_nxt = de_p1 ? (cnt_p2 + delta_q) : 5'sd0;
      cnt_chk = {cnt_p2[4], cnt_p2} + {delta_q[4], delta_q};
   end

   // ---- stage 2: DC balance and symbol register ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_p2  <= 5'sd0;
         tmds_p2 <= 10'b1101010100;
      end else begin
         cnt_p2  <= cnt_nxt;
         tmds_p2 <= tmds_nxt;
      end
   end

   assign tmds_o = tmds_p2;

   // Disparity must never leave the 5-bit range; a wrap means broken balancing logic.
   cnt_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !de_p1 || ((cnt_chk >= -6'sd16) && (cnt_chk <= 6'sd15)));

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: stimulus pushes expected symbols, a monitor pops and compares.
module tb_tmds_encoder;

   logic       clk_100 = 1'b0;
   logic       rst_n;
   logic       de;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic [9:0] tmds;

   always #5 clk_100 = ~clk_100;

   tmds_encoder dut (
      .clk_i  (clk_100),
      .rst_ni (rst_n),
      .de_i   (de),
      .data_i (data),
      .ctrl_i (ctrl),
      .tmds_o (tmds)
   );

   typedef struct {
      logic [9:0] exp;
      int         due;
      bit         is_data;
      int         tag;
   } exp_t;

   exp_t sb[$];
   int   mon_cyc  = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_cnt    = 0;
   int   run_sum  = 0;
   int   run_max  = 0;

   function automatic int ones10(input logic [9:0] s);
      int n;
      n = 0;
      for (int i = 0; i < 10; i++) n += int'(s[i]);
      return n;
   endfunction

   // Reference encoder with its own disparity counter.
   function automatic logic [9:0] ref_encode(input logic de_v, input logic [7:0] d, input logic [1:0] c);
      logic [8:0] qm;
      logic [9:0] s;
      int         n1d, n1, n0;
      if (!de_v) begin
         m_cnt = 0;
         case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
         endcase
         return s;
      end
      n1d = 0;
      for (int i = 0; i < 8; i++) n1d += int'(d[i]);
      qm    = '0;
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
         if (qm[8]) begin
            s = {2'b01, qm[7:0]};
            m_cnt += n1 - n0;
         end else begin
            s = {2'b10, ~qm[7:0]};
            m_cnt += n0 - n1;
         end
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         m_cnt += (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         m_cnt += n1 - n0 - (qm[8] ? 0 : 2);
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: tmds_o=%h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_now(input logic de_v, input logic [7:0] d, input logic [1:0] c,
                            input bit has_exp, input logic [9:0] exp_v, input int tag);
      exp_t e;
      de     = de_v;
      data   = d;
      ctrl   = c;
      e.exp  = ref_encode(de_v, d, c);
      if (has_exp) e.exp = exp_v;
      e.due     = mon_cyc + 2;
      e.is_data = de_v;
      e.tag     = tag;
      sb.push_back(e);
   endtask

   task automatic drive_exp(input logic de_v, input logic [7:0] d, input logic [1:0] c,
                            input logic [9:0] exp_v, input int tag);
      @(negedge clk_100);
      drive_now(de_v, d, c, 1'b1, exp_v, tag);
   endtask

   task automatic drive_ref(input logic de_v, input logic [7:0] d, input logic [1:0] c, input int tag);
      @(negedge clk_100);
      drive_now(de_v, d, c, 1'b0, 10'h000, tag);
   endtask

   // Asynchronous reset pulse between edges; the symbol already in stage 1 is lost.
   task automatic reset_pulse();
      @(negedge clk_100);
      #1 rst_n = 1'b0;
      #1 check("async_reset_tmds", tmds, 10'h354);
      rst_n = 1'b1;
      foreach (sb[i]) begin
         if (sb[i].due == mon_cyc + 1) begin
            sb[i].exp     = 10'h354;
            sb[i].is_data = 1'b0;
         end
      end
      m_cnt = 0;
   endtask

   // Monitor: compare every symbol that falls due this cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_100);
         #1;
         mon_cyc++;
         while (sb.size() > 0 && sb[0].due <= mon_cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (tmds !== e.exp) begin
               n_fail++;
               $display("FAIL sym tag %0d cyc %0d: tmds_o=%h expected %h", e.tag, mon_cyc, tmds, e.exp);
            end
            if (e.is_data) begin
               run_sum += 2 * ones10(tmds) - 10;
               if (run_sum > run_max)  run_max = run_sum;
               if (-run_sum > run_max) run_max = -run_sum;
            end else begin
               run_sum = 0;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      de    = 1'b1;
      data  = 8'hFF;
      ctrl  = 2'b11;
      repeat (3) @(posedge clk_100);
      #1 check("reset_tmds", tmds, 10'h354);
      @(negedge clk_100);
      rst_n = 1'b1;
      drive_now(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

      drive_exp(1'b0, 8'hA5, 2'b01, 10'h0AB, 1);
      drive_exp(1'b0, 8'h5A, 2'b10, 10'h154, 2);
      drive_exp(1'b0, 8'hFF, 2'b11, 10'h2AB, 3);
      drive_exp(1'b1, 8'h00, 2'b11, 10'h100, 4);
      drive_exp(1'b1, 8'h00, 2'b00, 10'h3FF, 5);
      drive_exp(1'b1, 8'h00, 2'b00, 10'h100, 6);
      drive_exp(1'b0, 8'h00, 2'b00, 10'h354, 7);
      drive_exp(1'b1, 8'hFF, 2'b00, 10'h200, 8);
      drive_exp(1'b0, 8'h33, 2'b00, 10'h354, 9);
      drive_exp(1'b1, 8'h01, 2'b00, 10'h1FF, 10);
      drive_exp(1'b1, 8'h01, 2'b00, 10'h300, 11);
      drive_exp(1'b0, 8'h00, 2'b00, 10'h354, 12);
      drive_exp(1'b1, 8'h1E, 2'b00, 10'h25F, 13);
      drive_exp(1'b1, 8'h0F, 2'b00, 10'h105, 14);
      drive_exp(1'b1, 8'h00, 2'b00, 10'h100, 15);
      drive_exp(1'b0, 8'h00, 2'b10, 10'h154, 16);
      drive_exp(1'b1, 8'h00, 2'b00, 10'h100, 17);
      drive_exp(1'b1, 8'h00, 2'b00, 10'h3FF, 18);

      reset_pulse();
      drive_now(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, 19);
      drive_exp(1'b1, 8'h00, 2'b00, 10'h3FF, 20);
      drive_exp(1'b0, 8'h00, 2'b00, 10'h354, 21);

      for (int b = 0; b < 2; b++) begin
         run_max = 0;
         for (int i = 0; i < 800; i++)
            drive_ref(1'b1, 8'($urandom), 2'($urandom), 1000 + i);
         for (int i = 0; i < 256; i++)
            drive_ref(1'b0, 8'($urandom), 2'($urandom), 2000 + i);
         n_checks++;
         if (run_max > 16) begin
            n_fail++;
            $display("FAIL burst_disparity %0d: max |running sum|=%0d allowed 16", b, run_max);
         end
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_100);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d symbols pending, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
